// File: rtl/rom_access_arbiter_if.sv
// Request/response and ROM-side signals shared by the ROM access arbiter and its clients.
interface rom_access_arbiter_if #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
);
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ-1:0]               rsp_valid;
  logic [DATA_WIDTH-1:0]            rsp_data;
  logic [ADDRESS_WIDTH-1:0]         rom_addr;
  logic [DATA_WIDTH-1:0]            rom_data;

  modport slave (
    input  req_valid, req_addr, rom_data,
    output req_ready, rsp_valid, rsp_data, rom_addr
  );

  modport master (
    output req_valid, req_addr, rom_data,
    input  req_ready, rsp_valid, rsp_data, rom_addr
  );
endinterface

// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter sharing one registered-read ROM among NUM_REQ requesters, 2-cycle tagged reads.
// Optional macro ROM_ARB_PRIO0_EN: requester 0 gets fixed top priority over the round-robin group.
module rom_access_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic              clk,
  input  logic              reset,
  rom_access_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [PTR_W-1:0] idx_t;

  idx_t                     ptr;
  idx_t                     grant_idx;
  logic                     grant_any;
  logic                     upd_ptr;
  logic                     accept;
  logic [NUM_REQ-1:0]       cand;
  logic [NUM_REQ-1:0]       ready;
  logic [NUM_REQ-1:0]       rsp_v;
  logic [ADDRESS_WIDTH-1:0] rom_addr_p1;
  idx_t                     tag_p1;
  idx_t                     tag_p2;
  logic                     vld_p1;
  logic                     vld_p2;

  function automatic idx_t wrap_idx(input idx_t p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return idx_t'(s);
  endfunction

  // Arbitration: first valid requester after the pointer, searching upward with wrap
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    upd_ptr   = 1'b0;
    cand      = bus.req_valid;
`ifdef ROM_ARB_PRIO0_EN
    cand[0] = 1'b0;
`endif
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_any && cand[wrap_idx(ptr, k)]) begin
        grant_any = 1'b1;
        grant_idx = wrap_idx(ptr, k);
        upd_ptr   = 1'b1;
      end
    end
`ifdef ROM_ARB_PRIO0_EN
    // Requester 0 preempts the round-robin group and leaves its pointer alone
    if (bus.req_valid[0]) begin
      grant_any = 1'b1;
      grant_idx = '0;
      upd_ptr   = 1'b0;
    end
`endif
    if (reset) begin
      grant_any = 1'b0;
      upd_ptr   = 1'b0;
    end
  end

  always_comb begin
    ready = '0;
    if (grant_any) ready[grant_idx] = 1'b1;
  end

  assign accept        = |(ready & bus.req_valid);
  assign bus.req_ready = ready;

  // Stage p1: registered ROM address and tag of the accepted request
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= idx_t'(NUM_REQ - 1);
      vld_p1      <= 1'b0;
      tag_p1      <= '0;
      rom_addr_p1 <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        rom_addr_p1 <= bus.req_addr[grant_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        tag_p1      <= grant_idx;
      end
      if (accept && upd_ptr) ptr <= grant_idx;
    end
  end

  // Stage p2: tag follows the ROM's own data register
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2 <= 1'b0;
      tag_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      tag_p2 <= tag_p1;
    end
  end

  always_comb begin
    rsp_v = '0;
    if (vld_p2 && !reset) rsp_v[tag_p2] = 1'b1;
  end

  assign bus.rsp_valid = rsp_v;
  assign bus.rsp_data  = bus.rom_data;
  assign bus.rom_addr  = rom_addr_p1;
endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter with a registered-read ROM model Mem[a] = a ^ 32'hA5A5_0000.
module tb_rom_access_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 12;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  logic [NR-1:0] hist_g [2];
  logic [AW-1:0] hist_a [2];

  rom_access_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  rom_access_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) bus.rom_data <= {{(DW-AW){1'b0}}, bus.rom_addr} ^ 32'hA5A5_0000;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    bus.req_addr[i*AW +: AW] = a;
  endtask

  task automatic clear_hist();
    hist_g[0] = '0; hist_g[1] = '0;
    hist_a[0] = '0; hist_a[1] = '0;
  endtask

  // Called just after a rising edge with inputs already driven; checks this cycle, advances one clock.
  task automatic cyc(input string tag, input logic [NR-1:0] eg);
    logic [AW-1:0] ga;
    #2;
    check({tag, " ready"}, 32'(bus.req_ready), 32'(eg));
    check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(hist_g[1]));
    if (hist_g[1] != '0)
      check({tag, " rsp_data"}, bus.rsp_data, {20'h0, hist_a[1]} ^ 32'hA5A5_0000);
    ga = '0;
    for (int i = 0; i < NR; i++)
      if (eg[i]) ga = bus.req_addr[i*AW +: AW];
    hist_g[1] = hist_g[0]; hist_a[1] = hist_a[0];
    hist_g[0] = eg;        hist_a[0] = ga;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_hist();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    clear_hist();

    // Reset state: no grants while reset is high, clean pipe afterwards
    @(posedge clk); #1;
    bus.req_valid = 4'hF;
    #2;
    check("reset ready", 32'(bus.req_ready), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req_valid = '0;
    check("reset rom_addr", 32'(bus.rom_addr), 32'h0);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'h0);

    // Test 1: single read
    do_reset();
    bus.req_valid = 4'b0001; set_addr(0, 12'h010);
    cyc("t1 c0", 4'b0001);
    bus.req_valid = '0;
    cyc("t1 c1", 4'b0000);
    cyc("t1 c2", 4'b0000);
    cyc("t1 c3", 4'b0000);

    // Test 2: all four held high -> 0,1,2,3,0,1,2,3
    do_reset();
    for (int i = 0; i < NR; i++) set_addr(i, AW'(i));
    bus.req_valid = 4'hF;
    cyc("t2 g0", 4'b0001);
    cyc("t2 g1", 4'b0010);
    cyc("t2 g2", 4'b0100);
    cyc("t2 g3", 4'b1000);
    cyc("t2 g4", 4'b0001);
    cyc("t2 g5", 4'b0010);
    cyc("t2 g6", 4'b0100);
    cyc("t2 g7", 4'b1000);
    bus.req_valid = '0;
    cyc("t2 d0", 4'b0000);
    cyc("t2 d1", 4'b0000);

    // Test 3: requester 2 alone, back-to-back addresses 0..7
    bus.req_valid = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      set_addr(2, AW'(k));
      cyc("t3 stream", 4'b0100);
    end
    bus.req_valid = '0;
    cyc("t3 d0", 4'b0000);
    cyc("t3 d1", 4'b0000);
    cyc("t3 d2", 4'b0000);

    // Test 4: reset with reads for 1 and 3 in flight
    do_reset();
    set_addr(1, 12'h111); set_addr(3, 12'h333); set_addr(0, 12'h020);
    bus.req_valid = 4'b0010;
    cyc("t4 g1", 4'b0010);
    bus.req_valid = 4'b1000;
    cyc("t4 g3", 4'b1000);
    reset = 1'b1;
    bus.req_valid = '0;
    #2;
    check("t4 rsp during reset", 32'(bus.rsp_valid), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_hist();
    #1;
    check("t4 rsp after reset", 32'(bus.rsp_valid), 32'h0);
    cyc("t4 idle", 4'b0000);
    bus.req_valid = 4'b1001;
    cyc("t4 0 wins", 4'b0001);
    bus.req_valid = '0;
    cyc("t4 d0", 4'b0000);
    cyc("t4 d1", 4'b0000);

    // Test 5: requesters 0 and 1 held high for 5 cycles
    do_reset();
    set_addr(0, 12'h0A0); set_addr(1, 12'h0B1);
    bus.req_valid = 4'b0011;
`ifdef ROM_ARB_PRIO0_EN
    for (int k = 0; k < 5; k++) cyc("t5 prio0", 4'b0001);
`else
    cyc("t5 g0", 4'b0001);
    cyc("t5 g1", 4'b0010);
    cyc("t5 g2", 4'b0001);
    cyc("t5 g3", 4'b0010);
    cyc("t5 g4", 4'b0001);
`endif
    bus.req_valid = '0;
    cyc("t5 d0", 4'b0000);
    cyc("t5 d1", 4'b0000);

    // Test 6: idle after a read of 3FF, rom_addr must hold
    bus.req_valid = 4'b0001; set_addr(0, 12'h3FF);
    cyc("t6 g", 4'b0001);
    bus.req_valid = '0;
    for (int k = 0; k < 10; k++) cyc("t6 idle", 4'b0000);
    #2;
    check("t6 rom_addr hold", 32'(bus.rom_addr), 32'h3FF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
